wall_scheduler: RTL and testbench

WALL_SCHEDULER -- requirements
Module: wall_scheduler

---
 rtl/wall_pkg.sv | 40 ++++
 rtl/wall_overlap_cmp.sv | 30 +++
 rtl/wall_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_wall_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wall_pkg.sv
// ============================================================================
// Module   : wall_pkg
// Purpose  : Shared types and constants for the wall layout scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GEN    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FINISH = 3'd4
  } wall_state_t;

  localparam logic [10:0] WALL_LONG       = 11'd64;
  localparam logic [10:0] WALL_SHORT      = 11'd32;
  localparam logic [15:0] LFSR_SEED       = 16'hACE1;
  localparam logic [9:0]  FALLBACK_X0     = 10'd16;
  localparam logic [9:0]  FALLBACK_X_STEP = 10'd144;
  localparam logic [9:0]  FALLBACK_Y      = 10'd16;

  // Index is zero-based: walls 1 and 3 are wide, walls 2 and 4 are tall.
  function automatic logic [10:0] wall_w(input logic [1:0] idx);
    return idx[0] ? WALL_SHORT : WALL_LONG;
  endfunction

  function automatic logic [10:0] wall_h(input logic [1:0] idx);
    return idx[0] ? WALL_LONG : WALL_SHORT;
  endfunction

  function automatic logic [9:0] fallback_x(input logic [1:0] idx);
    return FALLBACK_X0 + FALLBACK_X_STEP * {8'd0, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wall_overlap_cmp.sv
// ============================================================================
// Module   : wall_overlap_cmp
// Purpose  : Combinational test for overlap of two inclusive rectangles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_overlap_cmp (
  input  logic [10:0] ax,
  input  logic [10:0] ay,
  input  logic [10:0] aw,
  input  logic [10:0] ah,
  input  logic [10:0] bx,
  input  logic [10:0] by,
  input  logic [10:0] bw,
  input  logic [10:0] bh,
  output logic        overlap
);

  logic w_x_hit;
  logic w_y_hit;

  // Footprints span X..X+W inclusive, so touching edges count as overlap.
  assign w_x_hit = (ax <= bx + bw) && (bx <= ax + aw);
  assign w_y_hit = (ay <= by + bh) && (by <= ay + ah);
  assign overlap = w_x_hit && w_y_hit;

endmodule

`default_nettype wire

// File: rtl/wall_scheduler.sv
// ============================================================================
// Module   : wall_scheduler
// Purpose  : Generates up to four random wall positions and publishes them
//            on a frame boundary. Macro WALL_OVERLAP_CHECK_EN enables the
//            pairwise overlap rejection in CHECK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wall_scheduler
  import wall_pkg::*;
#(
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int MAX_TRIES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [2:0] num_walls,
  output logic       busy,
  output logic       done,
  output logic [9:0] X1,
  output logic [9:0] X2,
  output logic [9:0] X3,
  output logic [9:0] X4,
  output logic [9:0] Y1,
  output logic [9:0] Y2,
  output logic [9:0] Y3,
  output logic [9:0] Y4,
  output logic [3:0] wall_en
);

`ifdef WALL_OVERLAP_CHECK_EN
  localparam bit c_overlap_en = 1'b1;
`else
  localparam bit c_overlap_en = 1'b0;
`endif

  localparam int                   c_try_w    = $clog2(MAX_TRIES + 1);
  localparam logic [c_try_w-1:0]   c_try_last = c_try_w'(MAX_TRIES - 1);
  localparam logic [c_try_w-1:0]   c_try_one  = c_try_w'(1);
  localparam logic [10:0]          c_x_max    = 11'(X_MAX);
  localparam logic [10:0]          c_y_max    = 11'(Y_MAX);

  wall_state_t        r_state;
  logic [15:0]        r_lfsr;
  logic [2:0]         r_num;
  logic [1:0]         r_cur;
  logic [1:0]         r_chk;
  logic [c_try_w-1:0] r_try;
  logic [9:0]         r_cand_x;
  logic [9:0]         r_cand_y;
  logic [9:0]         r_wx [4];
  logic [9:0]         r_wy [4];
  logic [3:0]         r_wen;
  logic               r_pub;
  logic [2:0]         r_frm_sync;

  logic        w_lfsr_fb;
  logic [2:0]  w_nclamp;
  logic [10:0] w_cand_w;
  logic [10:0] w_cand_h;
  logic        w_oob;
  logic        w_overlap;
  logic        w_reject;
  logic        w_check_done;
  logic        w_frame_rise;

  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_nclamp     = num_walls[2] ? 3'd4 : num_walls;
  assign w_cand_w     = wall_w(r_cur);
  assign w_cand_h     = wall_h(r_cur);
  assign w_oob        = ({1'b0, r_cand_x} + w_cand_w > c_x_max) ||
                        ({1'b0, r_cand_y} + w_cand_h > c_y_max);
  assign w_frame_rise = r_frm_sync[1] & ~r_frm_sync[2];

  // Candidate versus the committed wall selected by r_chk.
  wall_overlap_cmp u_overlap (
    .ax      ({1'b0, r_cand_x}),
    .ay      ({1'b0, r_cand_y}),
    .aw      (w_cand_w),
    .ah      (w_cand_h),
    .bx      ({1'b0, r_wx[r_chk]}),
    .by      ({1'b0, r_wy[r_chk]}),
    .bw      (wall_w(r_chk)),
    .bh      (wall_h(r_chk)),
    .overlap (w_overlap)
  );

  assign w_reject     = w_oob || (c_overlap_en && (r_cur != 2'd0) && w_overlap);
  assign w_check_done = !c_overlap_en || (r_cur == 2'd0) || (r_chk + 2'd1 == r_cur);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_num      <= 3'd0;
      r_cur      <= 2'd0;
      r_chk      <= 2'd0;
      r_try      <= '0;
      r_cand_x   <= 10'd0;
      r_cand_y   <= 10'd0;
      r_wen      <= 4'd0;
      r_pub      <= 1'b0;
      r_frm_sync <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wall_en    <= 4'd0;
      X1 <= 10'd0; X2 <= 10'd0; X3 <= 10'd0; X4 <= 10'd0;
      Y1 <= 10'd0; Y2 <= 10'd0; Y3 <= 10'd0; Y4 <= 10'd0;
      for (int i = 0; i < 4; i++) begin
        r_wx[i] <= 10'd0;
        r_wy[i] <= 10'd0;
      end
    end else begin
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      r_frm_sync <= {r_frm_sync[1:0], frame_clk};
      done       <= 1'b0;

      // The FSM below may override r_pub in the same cycle.
      if (r_pub && w_frame_rise) begin
        r_pub   <= 1'b0;
        wall_en <= r_wen;
        X1 <= r_wx[0]; X2 <= r_wx[1]; X3 <= r_wx[2]; X4 <= r_wx[3];
        Y1 <= r_wy[0]; Y2 <= r_wy[1]; Y3 <= r_wy[2]; Y4 <= r_wy[3];
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num <= w_nclamp;
            r_cur <= 2'd0;
            r_try <= '0;
            r_wen <= 4'd0;
            r_pub <= 1'b0;
            if (w_nclamp == 3'd0) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_GEN;
              busy    <= 1'b1;
            end
          end
        end
        ST_GEN: begin
          r_cand_x <= r_lfsr[9:0];
          r_cand_y <= {1'b0, r_lfsr[15:7]};
          r_chk    <= 2'd0;
          r_state  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_reject) begin
            r_try <= r_try + c_try_one;
            if (r_try == c_try_last) begin
              r_cand_x <= fallback_x(r_cur);
              r_cand_y <= FALLBACK_Y;
              r_state  <= ST_COMMIT;
            end else begin
              r_state <= ST_GEN;
            end
          end else if (w_check_done) begin
            r_state <= ST_COMMIT;
          end else begin
            r_chk <= r_chk + 2'd1;
          end
        end
        ST_COMMIT: begin
          r_wx[r_cur]  <= r_cand_x;
          r_wy[r_cur]  <= r_cand_y;
          r_wen[r_cur] <= 1'b1;
          if ({1'b0, r_cur} + 3'd1 == r_num) begin
            r_state <= ST_FINISH;
            busy    <= 1'b0;
          end else begin
            r_cur   <= r_cur + 2'd1;
            r_try   <= '0;
            r_state <= ST_GEN;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          r_pub   <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wall_scheduler.sv
// ============================================================================
// Module   : tb_wall_scheduler
// Purpose  : Randomized self-checking bench for wall_scheduler; checks
//            layouts against placement rules rather than exact positions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wall_scheduler;

  localparam int XM = 639;
  localparam int YM = 479;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic       start_fb = 1'b0;
  logic [2:0] num_walls = 3'd0;
  logic [2:0] num_fb = 3'd0;
  logic       busy, done, busy_fb, done_fb;
  logic [9:0] X1, X2, X3, X4, Y1, Y2, Y3, Y4;
  logic [9:0] X1f, X2f, X3f, X4f, Y1f, Y2f, Y3f, Y4f;
  logic [3:0] wall_en, wall_en_fb;

  int n_checks = 0;
  int n_errors = 0;

  always #10 Clk = ~Clk;

  wall_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .num_walls(num_walls), .busy(busy), .done(done),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4), .wall_en(wall_en)
  );

  // Tiny legal area: every random candidate is out of bounds.
  wall_scheduler #(.X_MAX(40), .Y_MAX(20), .MAX_TRIES(15)) dut_fb (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start_fb),
    .num_walls(num_fb), .busy(busy_fb), .done(done_fb),
    .X1(X1f), .X2(X2f), .X3(X3f), .X4(X4f),
    .Y1(Y1f), .Y2(Y2f), .Y3(Y3f), .Y4(Y4f), .wall_en(wall_en_fb)
  );

  task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [83:0] outs();
    return {wall_en, X1, X2, X3, X4, Y1, Y2, Y3, Y4};
  endfunction

  function automatic int ww(int i);
    return (i % 2 == 0) ? 64 : 32;
  endfunction

  function automatic int wh(int i);
    return (i % 2 == 0) ? 32 : 64;
  endfunction

  task automatic run_layout(input logic [2:0] n, output int cyc);
    num_walls = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, (n != 3'd0));
    cyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("done_seen", done, 1'b1);
    tick();
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic publish_check();
    logic [83:0] pre, post;
    pre = outs();
    frame_clk = 1'b1;
    tick();
    tick();
    check("pub_not_early", outs(), pre);
    tick();
    post = outs();
    tick();
    tick();
    check("pub_single_step", outs(), post);
    frame_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_layout(input logic [2:0] n);
    int x[4], y[4];
    int m;
    bit in_b, fb;
    x[0] = int'(X1); x[1] = int'(X2); x[2] = int'(X3); x[3] = int'(X4);
    y[0] = int'(Y1); y[1] = int'(Y2); y[2] = int'(Y3); y[3] = int'(Y4);
    m = (n > 3'd4) ? 4 : int'(n);
    check("wall_en", wall_en, 84'((1 << m) - 1));
    for (int i = 0; i < 4; i++) begin
      if (i < m) begin
        in_b = (x[i] + ww(i) <= XM) && (y[i] + wh(i) <= YM);
        fb   = (x[i] == 16 + 144 * i) && (y[i] == 16);
        check($sformatf("bounds_w%0d", i + 1), (in_b || fb), 1'b1);
      end
    end
`ifdef WALL_OVERLAP_CHECK_EN
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < i; j++) begin
        check($sformatf("overlap_w%0d_w%0d", j + 1, i + 1),
              (x[i] <= x[j] + ww(j)) && (x[j] <= x[i] + ww(i)) &&
              (y[i] <= y[j] + wh(j)) && (y[j] <= y[i] + wh(i)), 1'b0);
      end
    end
`endif
  endtask

  initial begin
    int cyc, dcnt, changed;
    logic [2:0] n;
    logic [83:0] pre;

    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_outs", outs(), 84'd0);

    // Random wall counts, including the clamped 5..7 range.
    for (int it = 0; it < 12; it++) begin
      n = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 4)) tick();
      run_layout(n, cyc);
      publish_check();
      check_layout(n);
    end

    // A new start discards the pending publish of the previous layout.
    run_layout(3'd1, cyc);
    publish_check();
    check_layout(3'd1);
    run_layout(3'd4, cyc);
    num_walls = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    frame_clk = 1'b1;
    repeat (5) tick();
    check("no_partial_pub", wall_en, 4'b0001);
    frame_clk = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("done_after_restart", done, 1'b1);
    tick();
    publish_check();
    check_layout(3'd4);

    // Starts while busy are ignored.
    num_walls = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    num_walls = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    dcnt = 0;
    repeat (400) begin
      if (done) dcnt++;
      tick();
    end
    check("single_done", dcnt, 1);
    publish_check();
    check_layout(3'd3);

    // Outputs hold without a frame edge.
    run_layout(3'd2, cyc);
    pre = outs();
    changed = 0;
    repeat (10000) begin
      tick();
      if (outs() !== pre) changed++;
    end
    check("hold_no_frame", changed, 0);
    publish_check();
    check_layout(3'd2);

    // Zero walls: done two cycles after start, empty mask published.
    run_layout(3'd0, cyc);
    check("n0_done_latency", cyc, 1);
    publish_check();
    check_layout(3'd0);

    // Reset in the middle of generation.
    run_layout(3'd4, cyc);
    publish_check();
    check_layout(3'd4);
    num_walls = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    Reset_n = 1'b0;
    #5;
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_outs", outs(), 84'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    check("rst_rel_busy", busy, 1'b0);
    check("rst_rel_done", done, 1'b0);
    check("rst_rel_outs", outs(), 84'd0);
    publish_check();
    check("rst_no_pub", outs(), 84'd0);

    // Fallback positions when every candidate is rejected.
    num_fb = 3'd4;
    start_fb = 1'b1;
    tick();
    start_fb = 1'b0;
    cyc = 0;
    while (!done_fb && cyc < 5000) begin
      tick();
      cyc++;
    end
    check("fb_done", done_fb, 1'b1);
    tick();
    publish_check();
    check("fb_wall_en", wall_en_fb, 4'b1111);
    check("fb_X1", X1f, 10'd16);
    check("fb_Y1", Y1f, 10'd16);
    check("fb_X2", X2f, 10'd160);
    check("fb_Y2", Y2f, 10'd16);
    check("fb_X3", X3f, 10'd304);
    check("fb_Y3", Y3f, 10'd16);
    check("fb_X4", X4f, 10'd448);
    check("fb_Y4", Y4f, 10'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
